// File: rtl/gb_camera_mbc.sv
// gb_camera_mbc: Pocket Camera cart mapper with a camera register window.
// Decodes CPU cart-bus writes into ROM/RAM bank and enable registers and
// forms masked ROM / cart-RAM byte addresses. Optional build macro
// GB_CAMERA_CAPTURE_EN adds the capture sequencer (busy/done status and
// cart-RAM blocking while a capture runs).
module gb_camera_mbc #(
    parameter int ROM_BANK_W      = 6,
    parameter int RAM_BANK_W      = 4,
    parameter int CAP_BASE_CYCLES = 1024
) (
    input  logic                  clk_sys,
    input  logic                  reset_n,
    input  logic                  ce_cpu,
    input  logic [ROM_BANK_W-1:0] rom_mask,
    input  logic [RAM_BANK_W-1:0] ram_mask,
    input  logic [14:0]           cart_addr,
    input  logic                  cart_a15,
    input  logic                  nCS,
    input  logic                  cart_rd,
    input  logic                  cart_wr,
    input  logic [7:0]            cart_di,
    input  logic [7:0]            cram_di,
    output logic [7:0]            cart_do,
    output logic                  cart_oe,
    output logic [22:0]           mbc_addr,
    output logic [16:0]           cram_addr,
    output logic                  cram_wr,
    output logic                  cam_en,
    output logic                  cap_busy,
    output logic                  cap_done
);

    logic                  wr_ce;
    logic                  win;
    logic                  cam_wr;
    logic                  reg0_wr;
    logic                  idx0;
    logic [ROM_BANK_W-1:0] rom_bank_reg;
    logic [ROM_BANK_W-1:0] rom_bank;
    logic [RAM_BANK_W-1:0] ram_bank_reg;
    logic                  ram_write_en;
    logic [1:0]            reg0_bits;

    assign wr_ce   = ce_cpu & cart_wr;
    assign win     = ~nCS & ~cart_addr[14];
    assign idx0    = (cart_addr[5:0] == 6'd0);
    assign cam_wr  = wr_ce & cam_en & win;
    assign reg0_wr = cam_wr & idx0;

    // MBC control registers written through the 0x0000-0x7FFF range
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            rom_bank_reg <= ROM_BANK_W'(1);
            ram_bank_reg <= '0;
            ram_write_en <= 1'b0;
            cam_en       <= 1'b0;
        end else if (wr_ce && !cart_a15) begin
            case (cart_addr[14:13])
                2'b00: ram_write_en <= (cart_di[3:0] == 4'hA);
                2'b01: rom_bank_reg <= ROM_BANK_W'(cart_di);
                2'b10: begin
                    cam_en       <= cart_di[4];
                    ram_bank_reg <= RAM_BANK_W'(cart_di);
                end
                default: ;
            endcase
        end
    end

`ifdef GB_CAMERA_CAPTURE_EN
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_EXPOSE = 2'd1,
        S_DONE   = 2'd2
    } cap_state_t;

    cap_state_t  state, state_nx;
    logic [16:0] cnt, cnt_nx;
    logic [7:0]  exp_hi;
    logic [7:0]  exp_lo;

    // Camera register window; only reg0 bits and the exposure pair have an effect
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            reg0_bits <= 2'b00;
            exp_hi    <= 8'h00;
            exp_lo    <= 8'h00;
        end else if (cam_wr) begin
            case (cart_addr[5:0])
                6'd0: reg0_bits <= cart_di[2:1];
                6'd2: exp_hi    <= cart_di;
                6'd3: exp_lo    <= cart_di;
                default: ;
            endcase
        end
    end

    // Capture sequencer state and tick counter
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    // Capture next-state: trigger loads the length, abort wins over counting
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        case (state)
            S_IDLE: begin
                if (reg0_wr && cart_di[0]) begin
                    state_nx = S_EXPOSE;
                    cnt_nx   = 17'(CAP_BASE_CYCLES) + 17'({exp_hi, exp_lo});
                end
            end
            S_EXPOSE: begin
                if (reg0_wr && !cart_di[0]) begin
                    state_nx = S_IDLE;
                    cnt_nx   = '0;
                end else if (ce_cpu) begin
                    if (cnt <= 17'd1) begin
                        state_nx = S_DONE;
                        cnt_nx   = '0;
                    end else begin
                        cnt_nx = cnt - 17'd1;
                    end
                end
            end
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    assign cap_busy = (state == S_EXPOSE);
    assign cap_done = (state == S_DONE);
`else
    logic unused_di;

    // Camera register window; without the sequencer only reg0 bits are kept
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            reg0_bits <= 2'b00;
        end else if (reg0_wr) begin
            reg0_bits <= cart_di[2:1];
        end
    end

    assign unused_di = ^cart_di[7:5];
    assign cap_busy  = 1'b0;
    assign cap_done  = 1'b0;
`endif

    assign rom_bank  = cart_addr[14] ? rom_bank_reg : '0;
    assign mbc_addr  = 23'({rom_bank & rom_mask, cart_addr[13:0]});
    assign cram_addr = 17'({ram_bank_reg & ram_mask, cart_addr[12:0]});
    assign cram_wr   = wr_ce & win & ram_write_en & ~cam_en & ~cap_busy;
    assign cart_oe   = cart_rd & (~cart_a15 | win);

    // Read mux for the cart-RAM / camera window
    always_comb begin
        cart_do = 8'h00;
        if (cam_en) begin
            if (idx0) cart_do = {5'b0, reg0_bits, cap_busy};
        end else if (!cap_busy) begin
            cart_do = cram_di;
        end
    end

endmodule

// File: tb/tb_gb_camera_mbc.sv
// tb_gb_camera_mbc: directed bench with a behavioural mapper model and a
// per-cycle output compare. Works with or without GB_CAMERA_CAPTURE_EN.
module tb_gb_camera_mbc;

    localparam int ROM_BANK_W = 6;
    localparam int RAM_BANK_W = 4;
    localparam int CAP_BASE   = 1024;

    logic                  clk_sys;
    logic                  reset_n;
    logic                  ce_cpu;
    logic [ROM_BANK_W-1:0] rom_mask;
    logic [RAM_BANK_W-1:0] ram_mask;
    logic [14:0]           cart_addr;
    logic                  cart_a15;
    logic                  nCS;
    logic                  cart_rd;
    logic                  cart_wr;
    logic [7:0]            cart_di;
    logic [7:0]            cram_di;
    logic [7:0]            cart_do;
    logic                  cart_oe;
    logic [22:0]           mbc_addr;
    logic [16:0]           cram_addr;
    logic                  cram_wr;
    logic                  cam_en;
    logic                  cap_busy;
    logic                  cap_done;

    gb_camera_mbc #(
        .ROM_BANK_W(ROM_BANK_W),
        .RAM_BANK_W(RAM_BANK_W),
        .CAP_BASE_CYCLES(CAP_BASE)
    ) dut (
        .clk_sys(clk_sys), .reset_n(reset_n), .ce_cpu(ce_cpu),
        .rom_mask(rom_mask), .ram_mask(ram_mask),
        .cart_addr(cart_addr), .cart_a15(cart_a15), .nCS(nCS),
        .cart_rd(cart_rd), .cart_wr(cart_wr), .cart_di(cart_di),
        .cram_di(cram_di), .cart_do(cart_do), .cart_oe(cart_oe),
        .mbc_addr(mbc_addr), .cram_addr(cram_addr), .cram_wr(cram_wr),
        .cam_en(cam_en), .cap_busy(cap_busy), .cap_done(cap_done)
    );

    initial clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    int tests       = 0;
    int failed      = 0;
    int wr_pulses   = 0;
    int done_pulses = 0;
    bit cmp_en      = 0;

    // Behavioural model state
    int m_rom_bank = 1;
    int m_ram_bank = 0;
    bit m_ram_we   = 0;
    bit m_cam_en   = 0;
    int m_reg0     = 0;
    int m_exp      = 0;
    bit m_busy     = 0;
    bit m_done     = 0;
    int m_left     = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model update on each clock edge from the bus rules
    always @(posedge clk_sys) begin
        bit wr, win, camw, r0;
        if (!reset_n) begin
            m_rom_bank = 1; m_ram_bank = 0; m_ram_we = 0; m_cam_en = 0;
            m_reg0 = 0; m_exp = 0; m_busy = 0; m_done = 0; m_left = 0;
        end else begin
            wr   = ce_cpu && cart_wr;
            win  = !nCS && !cart_addr[14];
            camw = wr && m_cam_en && win;
            r0   = camw && (cart_addr[5:0] == 6'd0);
`ifdef GB_CAMERA_CAPTURE_EN
            if (m_done) begin
                m_done = 0;
            end else if (m_busy) begin
                if (r0 && !cart_di[0]) begin
                    m_busy = 0;
                end else if (ce_cpu) begin
                    m_left = m_left - 1;
                    if (m_left == 0) begin
                        m_busy = 0;
                        m_done = 1;
                    end
                end
            end else if (r0 && cart_di[0]) begin
                m_busy = 1;
                m_left = CAP_BASE + m_exp;
            end
`endif
            if (camw) begin
                if (cart_addr[5:0] == 6'd0) m_reg0 = int'(cart_di[2:1]);
                if (cart_addr[5:0] == 6'd2) m_exp = int'(cart_di) * 256 + (m_exp % 256);
                if (cart_addr[5:0] == 6'd3) m_exp = (m_exp / 256) * 256 + int'(cart_di);
            end
            if (wr && !cart_a15) begin
                if (cart_addr[14:13] == 2'd0) m_ram_we = (cart_di[3:0] == 4'hA);
                if (cart_addr[14:13] == 2'd1) m_rom_bank = int'(cart_di) % (1 << ROM_BANK_W);
                if (cart_addr[14:13] == 2'd2) begin
                    m_cam_en   = cart_di[4];
                    m_ram_bank = int'(cart_di) % (1 << RAM_BANK_W);
                end
            end
        end
    end

    // Per-cycle compare of every output against the model
    always @(negedge clk_sys) begin
        int e_mbc, e_cram, e_do;
        bit e_win, e_wr, e_oe;
        if (cmp_en) begin
            e_win  = !nCS && !cart_addr[14];
            e_mbc  = (((cart_addr[14] ? m_rom_bank : 0) & int'(rom_mask)) * 16384) + int'(cart_addr[13:0]);
            e_cram = ((m_ram_bank & int'(ram_mask)) * 8192) + int'(cart_addr[12:0]);
            e_wr   = ce_cpu && cart_wr && e_win && m_ram_we && !m_cam_en && !m_busy;
            e_oe   = cart_rd && (!cart_a15 || e_win);
            if (m_cam_en) e_do = (cart_addr[5:0] == 6'd0) ? (m_reg0 * 2 + int'(m_busy)) : 0;
            else          e_do = m_busy ? 0 : int'(cram_di);
            check("cmp_mbc_addr", 32'(mbc_addr), e_mbc);
            check("cmp_cram_addr", 32'(cram_addr), e_cram);
            check("cmp_cram_wr", 32'(cram_wr), 32'(e_wr));
            check("cmp_cart_oe", 32'(cart_oe), 32'(e_oe));
            check("cmp_cart_do", 32'(cart_do), e_do);
            check("cmp_cam_en", 32'(cam_en), 32'(m_cam_en));
            check("cmp_cap_busy", 32'(cap_busy), 32'(m_busy));
            check("cmp_cap_done", 32'(cap_done), 32'(m_done));
        end
        if (cram_wr === 1'b1) wr_pulses++;
        if (cap_done === 1'b1) done_pulses++;
    end

    task automatic cycle();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic put_addr(input logic [15:0] a);
        cart_a15  = a[15];
        cart_addr = a[14:0];
        nCS       = !(a >= 16'hA000);
    endtask

    task automatic bus_write(input logic [15:0] a, input logic [7:0] d);
        put_addr(a);
        cart_di = d;
        cart_wr = 1'b1;
        cart_rd = 1'b0;
        ce_cpu  = 1'b1;
        cycle();
        cart_wr = 1'b0;
    endtask

    task automatic bus_read(input logic [15:0] a);
        put_addr(a);
        cart_wr = 1'b0;
        cart_rd = 1'b1;
        #1;
    endtask

    // Start a RAM-window write and sample cram_wr before the edge
    task automatic ram_write_probe(input logic [15:0] a, input logic [7:0] d, input logic exp_wr);
        put_addr(a);
        cart_di = d;
        cart_wr = 1'b1;
        cart_rd = 1'b0;
        ce_cpu  = 1'b1;
        #1;
        check("probe_cram_wr", 32'(cram_wr), 32'(exp_wr));
        cycle();
        cart_wr = 1'b0;
    endtask

`ifdef GB_CAMERA_CAPTURE_EN
    // Run until capture ends, counting ce_cpu ticks while busy
    task automatic wait_capture(output int ticks);
        ticks = 0;
        for (int c = 0; c < 6000 && cap_busy === 1'b1; c++) begin
            ce_cpu = (c % 3 != 2);
            @(posedge clk_sys);
            if (ce_cpu) ticks++;
            #1;
        end
        ce_cpu = 1'b1;
        check("capture_timeout_busy", 32'(cap_busy), 32'd0);
    endtask
`endif

    initial begin
        int p, d0, ticks;
        reset_n  = 1'b0;
        ce_cpu   = 1'b1;
        rom_mask = 6'h3F;
        ram_mask = 4'hF;
        cart_addr = '0;
        cart_a15 = 1'b0;
        nCS      = 1'b1;
        cart_rd  = 1'b0;
        cart_wr  = 1'b0;
        cart_di  = 8'h00;
        cram_di  = 8'h5C;
        cycle();
        cycle();
        cmp_en = 1;
        check("reset_busy", 32'(cap_busy), 32'd0);
        check("reset_done", 32'(cap_done), 32'd0);
        check("reset_cam_en", 32'(cam_en), 32'd0);
        check("reset_cram_wr", 32'(cram_wr), 32'd0);
        reset_n = 1'b1;

        // ROM banking and masking
        bus_read(16'h4000);
        check("rom_reset_bank", 32'(mbc_addr), 32'h04000);
        bus_write(16'h2000, 8'h25);
        bus_read(16'h7FFF);
        check("rom_bank_25", 32'(mbc_addr), 32'h97FFF);
        rom_mask = 6'h0F;
        #1;
        check("rom_mask_0F", 32'(mbc_addr), 32'h17FFF);
        rom_mask = 6'h3F;
        bus_read(16'h0123);
        check("rom_bank0_area", 32'(mbc_addr), 32'h00123);

        // Cart RAM writes gated by the enable register
        bus_write(16'h0000, 8'h0A);
        bus_write(16'h4000, 8'h03);
        p = wr_pulses;
        put_addr(16'hA123);
        #1;
        check("ram_addr_bank3", 32'(cram_addr), 32'h06123);
        ram_write_probe(16'hA123, 8'h5A, 1'b1);
        cycle();
        check("ram_write_once", 32'(wr_pulses - p), 32'd1);
        bus_write(16'h0000, 8'h00);
        p = wr_pulses;
        ram_write_probe(16'hA123, 8'h5A, 1'b0);
        cycle();
        check("ram_write_disabled", 32'(wr_pulses - p), 32'd0);
        bus_read(16'hA123);
        check("ram_read_oe", 32'(cart_oe), 32'd1);
        check("ram_read_data", 32'(cart_do), 32'h5C);

`ifdef GB_CAMERA_CAPTURE_EN
        // Full capture with exposure 0x0010
        bus_write(16'h4000, 8'h10);
        bus_write(16'hA002, 8'h00);
        bus_write(16'hA003, 8'h10);
        d0 = done_pulses;
        bus_write(16'hA000, 8'h01);
        bus_read(16'hA000);
        check("cap_busy_after_trigger", 32'(cap_busy), 32'd1);
        check("cap_reg0_busy_read", 32'(cart_do), 32'h01);
        wait_capture(ticks);
        check("capture_length", ticks, CAP_BASE + 16);
        check("cap_done_high", 32'(cap_done), 32'd1);
        cycle();
        check("cap_done_low", 32'(cap_done), 32'd0);
        check("cap_reg0_idle_read", 32'(cart_do), 32'h00);
        check("cap_done_once", 32'(done_pulses - d0), 32'd1);

        // RAM blocked during a capture with the window switched to RAM
        bus_write(16'h0000, 8'h0A);
        bus_write(16'hA000, 8'h01);
        bus_write(16'h4000, 8'h00);
        ram_write_probe(16'hA010, 8'h77, 1'b0);
        bus_read(16'hA010);
        check("busy_blocks_read", 32'(cart_do), 32'h00);
        wait_capture(ticks);
        check("blocked_cap_done", 32'(cap_done), 32'd1);
        cycle();
        bus_read(16'hA010);
        check("ram_read_after_cap", 32'(cart_do), 32'h5C);
        ram_write_probe(16'hA010, 8'h77, 1'b1);

        // Abort by clearing the trigger bit
        bus_write(16'h4000, 8'h10);
        bus_write(16'hA000, 8'h01);
        repeat (5) cycle();
        check("abort_busy_before", 32'(cap_busy), 32'd1);
        d0 = done_pulses;
        bus_write(16'hA000, 8'h06);
        check("abort_busy_after", 32'(cap_busy), 32'd0);
        bus_read(16'hA000);
        check("abort_reg0_read", 32'(cart_do), 32'h06);
        repeat (3) cycle();
        check("abort_no_done", 32'(done_pulses - d0), 32'd0);

        // Reset in the middle of a capture
        bus_write(16'hA000, 8'h01);
        repeat (4) cycle();
        d0 = done_pulses;
        reset_n = 1'b0;
        cycle();
        reset_n = 1'b1;
        check("rst_busy", 32'(cap_busy), 32'd0);
        check("rst_cam_en", 32'(cam_en), 32'd0);
        bus_read(16'h4000);
        check("rst_rom_bank", 32'(mbc_addr), 32'h04000);
        ram_write_probe(16'hA123, 8'h11, 1'b0);
        bus_write(16'h4000, 8'h10);
        bus_read(16'hA000);
        check("rst_reg0_read", 32'(cart_do), 32'h00);
        check("rst_no_done", 32'(done_pulses - d0), 32'd0);
        bus_write(16'hA000, 8'h01);
        wait_capture(ticks);
        check("rst_exposure_cleared", ticks, CAP_BASE);
        check("rst_cap_done", 32'(cap_done), 32'd1);
        cycle();
`else
        // Without the sequencer a trigger has no effect
        bus_write(16'h4000, 8'h10);
        bus_write(16'hA000, 8'h01);
        check("nocap_busy", 32'(cap_busy), 32'd0);
        bus_read(16'hA000);
        check("nocap_reg0_read", 32'(cart_do), 32'h00);
        bus_write(16'hA000, 8'h07);
        bus_read(16'hA000);
        check("nocap_reg0_bits", 32'(cart_do), 32'h06);
        check("nocap_done", 32'(cap_done), 32'd0);
        bus_write(16'h4000, 8'h00);
        bus_write(16'h0000, 8'h0A);
        ram_write_probe(16'hA055, 8'h33, 1'b1);
        bus_read(16'hA055);
        check("nocap_ram_read", 32'(cart_do), 32'h5C);
`endif

        cycle();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/gb_camera_mbc.md
# gb_camera_mbc

Parametrised Pocket Camera mapper for the GB core: decodes CPU cart-bus writes into ROM/RAM bank and enable registers, and produces masked ROM and cart-RAM addresses. It adds an internal camera register window with a capture sequencer that reports a busy status and blocks cart-RAM access while a capture runs. It sits between the CPU cart bus and the SDRAM/BRAM cart memories, in place of the fixed-width camera mapper.

## Interface
- ROM_BANK_W, 6: ROM bank register width; legal range 1..9.
- RAM_BANK_W, 4: RAM bank register width; legal range 1..4.
- CAP_BASE_CYCLES, 1024: fixed capture overhead, counted in ce_cpu ticks.
- clk_sys  in  1  system clock; the block's only clock.
- reset_n  in  1  synchronous, active-low reset.
- ce_cpu  in  1  CPU clock enable; qualifies all register writes and counting.
- rom_mask  in  ROM_BANK_W  ROM bank mirror mask.
- ram_mask  in  RAM_BANK_W  RAM bank mirror mask.
- cart_addr  in  15  CPU address bits 14:0.
- cart_a15  in  1  CPU address bit 15.
- nCS  in  1  active-low select for 0xA000-0xFFFF.
- cart_rd / cart_wr  in  1 each  CPU read / write strobes.
- cart_di  in  8  CPU write data.
- cram_di  in  8  read data from cart RAM.
- cart_do  out  8  read data to CPU for the cart-RAM/camera window.
- cart_oe  out  1  cart drives the data bus.
- mbc_addr  out  23  ROM byte address.
- cram_addr  out  17  cart RAM byte address.
- cram_wr  out  1  cart RAM write strobe.
- cam_en  out  1  camera register window selected.
- cap_busy  out  1  capture in progress.
- cap_done  out  1  single-clk_sys pulse when a capture completes.

## Operation
- A write is `ce_cpu & cart_wr`.
- Writes with `cart_a15=0` are decoded on `cart_addr[14:13]`:
  - 00: `ram_write_en <= (cart_di[3:0]==4'hA)`.
  - 01: `rom_bank_reg <= cart_di[ROM_BANK_W-1:0]`. A value of 0 selects bank 0; there is no 0→1 remap.
  - 10: `cam_en <= cart_di[4]`, and `ram_bank_reg <= cart_di[RAM_BANK_W-1:0]`.
  - 11: ignored.
- ROM address:
  - `rom_bank = cart_addr[14] ? rom_bank_reg : 0`.
  - `mbc_addr = zero-extend({rom_bank & rom_mask, cart_addr[13:0]})`.
- RAM address: `cram_addr = zero-extend({ram_bank_reg & ram_mask, cart_addr[12:0]})`.
- The window is active when `win = ~nCS & ~cart_addr[14]`.
- cram_wr is asserted when a write hits `win`, `ram_write_en=1`, `cam_en=0`, and `cap_busy=0`.
- Camera registers apply when `cam_en=1` and the access hits `win`. The register index is `cart_addr[5:0]`; indices 0..53 are valid and higher indices are ignored.
  - reg0 stores bits [2:1]. Bit 0 is the capture trigger.
  - reg1..reg53 are 8-bit and write-only.
  - Exposure is `{reg2, reg3}`.
- Read data on cart_do:
  - `cam_en=1`: reg0 returns `{5'b0, reg0[2:1], cap_busy}`; all other indices return 0x00.
  - `cam_en=0`: returns `cap_busy ? 8'h00 : cram_di`.
- `cart_oe = (cart_rd & ~cart_a15) | (cart_rd & win)`.
- Capture FSM (state advances only on ce_cpu):
  - IDLE: a reg0 write with bit0=1 loads `cnt = CAP_BASE_CYCLES + {reg2,reg3}` (17-bit, no overflow) and moves to EXPOSE. reg2/reg3 values are those before the write.
  - EXPOSE:
    - Each ce_cpu decrements cnt. When cnt reaches 0, the FSM moves to DONE.
    - A reg0 write with bit0=0 aborts to IDLE immediately, with no cap_done.
    - A reg0 write with bit0=1 is ignored (no restart); bits [2:1] still update.
  - DONE: lasts exactly one clk_sys cycle, independent of ce_cpu. `cap_done=1`, then the FSM returns to IDLE.
- `cap_busy = (state == EXPOSE)`.
- Writing reg2/reg3 during EXPOSE does not alter cnt.
- Clearing cam_en during EXPOSE does not stop the capture.
- Reset values:
  - `rom_bank_reg=1`, `ram_bank_reg=0`, `ram_write_en=0`, `cam_en=0`.
  - All camera registers 0, state IDLE, cnt 0.
  - Outputs: `cap_busy=0`, `cap_done=0`, `cram_wr=0`.

## Timing
- All registers and the FSM update on the rising edge of clk_sys.
- reset_n is sampled synchronously. A reset asserted mid-capture returns the block to IDLE on the next edge, with no cap_done.
- Register writes take effect on the clk_sys edge where `ce_cpu & cart_wr` holds. Their effect on mbc_addr, cram_addr and cart_do is visible the following cycle.
- mbc_addr, cram_addr, cram_wr, cart_do and cart_oe are combinational from the inputs and the current registers (zero latency).
- The trigger write moves the FSM to EXPOSE at that edge, so cap_busy is 1 on the next cycle.
- Capture length is exactly `CAP_BASE_CYCLES + exposure` ce_cpu ticks from the trigger edge (the trigger tick excluded) to EXPOSE→DONE.
- Read-during-trigger returns the pre-write busy value.

## Configuration
- `GB_CAMERA_CAPTURE_EN` defined: the capture FSM, counter, cap_busy gating and cap_done are present as described above.
- Not defined:
  - No FSM; cap_busy and cap_done are tied to 0.
  - reg0 bit0 always reads 0.
  - Trigger writes have no effect.
  - cram_wr and cart_do never depend on capture state.

## Test plan
- Reset, then read 0x4000 with `rom_mask=6'h3F` → `mbc_addr=0x04000`. Write 0x2000←0x25, read 0x7FFF → `mbc_addr=0x97FFF`. Set `rom_mask=6'h0F` → `0x17FFF`.
- Write 0x0000←0x0A and 0x4000←0x03, then write 0xA123←0x5A → cram_wr pulses once with `cram_addr=0x06123`. Write 0x0000←0x00 and repeat → no cram_wr.
- Write 0x4000←0x10, 0xA002←0x00, 0xA003←0x10, then 0xA000←0x01 → cap_busy=1 for exactly 1024+16 ce_cpu ticks; reads of 0xA000 return 0x01; cap_done pulses one cycle; a final read returns 0x00.
- During a capture, write 0x4000←0x00 and try a RAM write → cram_wr stays 0 and cart_do=0x00. After cap_done, RAM reads return cram_di.
- Mid-capture write 0xA000←0x06 → FSM to IDLE, no cap_done, reg0 reads 0x06. Separately, mid-capture reset_n=0 for one cycle → all reset values restored.
- Build without GB_CAMERA_CAPTURE_EN: trigger write → cap_busy stays 0, reg0 reads 0x00, RAM writes proceed normally.
